// File: rtl/lc3b_memory.sv
// lc3b_memory
//   Word-organized main memory for the LC-3b MAR/MDR interface. A request is
//   accepted while idle, runs a fixed-latency countdown, then completes with a
//   one-cycle R pulse (and ERR for an unaligned word access).
//
// Parameters
//   WORDS     number of 16-bit words (power of two); index = MAR[15:1] mod WORDS
//   LATENCY   cycles from first MIO_EN-high cycle to the R cycle, inclusive (>= 2)
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   MIO_EN     memory request, held high until R
//   R_W        0 = read, 1 = write
//   DATA_SIZE  0 = byte, 1 = word
//   MAR        byte address
//   MDR_IN     write data (byte writes arrive replicated in both halves)
//   MEM_OUT    registered read data, holds until the next completed read
//   R          ready, one-cycle pulse at completion
//   ERR        one-cycle pulse with R on an unaligned word access
module lc3b_memory #(
    parameter int WORDS   = 32768,
    parameter int LATENCY = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic        DATA_SIZE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR_IN,
    output logic [15:0] MEM_OUT,
    output logic        R,
    output logic        ERR
);

    localparam int AW = $clog2(WORDS);
    localparam int CW = $clog2(LATENCY + 1);
    // One cycle is spent in IDLE accepting and one in DONE, so BUSY lasts
    // LATENCY-2 cycles; the counter expires at zero, hence the -3 load.
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 2) ? (LATENCY - 3) : 0);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic           r_rw;
    logic           r_size;
    logic [15:0]    r_mar;
    logic [15:0]    r_mdr;
    logic [15:0]    r_mem_out;
    logic           r_r;
    logic           r_err;
    logic [15:0]    r_mem [WORDS];

    logic           w_accept;
    logic           w_access;
    logic           w_rw;
    logic           w_size;
    logic [15:0]    w_mar;
    logic [15:0]    w_mdr;
    logic           w_unaligned;
    logic [AW-1:0]  w_idx;
    logic           w_we_lo;
    logic           w_we_hi;
    logic           w_rd;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_access = 1'b0;
        case (r_state)
            IDLE: begin
                if (MIO_EN) begin
                    w_accept = 1'b1;
                    // With the minimum latency there is no BUSY phase at all.
                    if (LATENCY == 2) begin
                        w_access = 1'b1;
                        w_next   = DONE;
                    end else begin
                        w_next   = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!MIO_EN) begin
                    w_next = IDLE;
                end else if (r_cnt == '0) begin
                    w_access = 1'b1;
                    w_next   = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The access normally uses the latched request; only the LATENCY==2 path
    // completes straight out of IDLE, where the live inputs are the request.
    assign w_rw        = (r_state == IDLE) ? R_W       : r_rw;
    assign w_size      = (r_state == IDLE) ? DATA_SIZE : r_size;
    assign w_mar       = (r_state == IDLE) ? MAR       : r_mar;
    assign w_mdr       = (r_state == IDLE) ? MDR_IN    : r_mdr;
    assign w_unaligned = w_size & w_mar[0];
    assign w_idx       = w_mar[AW:1];
    assign w_we_lo     = w_access & w_rw & ~w_unaligned & (w_size | ~w_mar[0]);
    assign w_we_hi     = w_access & w_rw & ~w_unaligned & (w_size |  w_mar[0]);
    assign w_rd        = w_access & ~w_rw & ~w_unaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rw      <= 1'b0;
            r_size    <= 1'b0;
            r_mar     <= '0;
            r_mdr     <= '0;
            r_mem_out <= '0;
            r_r       <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_r   <= w_access;
            r_err <= w_access & w_unaligned;
            if (w_accept) begin
                r_rw   <= R_W;
                r_size <= DATA_SIZE;
                r_mar  <= MAR;
                r_mdr  <= MDR_IN;
                r_cnt  <= CNT_LOAD;
            end else if (r_state == BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_rd) r_mem_out <= r_mem[w_idx];
        end
    end

    // Array is never cleared; a reset on the completing edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && w_we_lo) r_mem[w_idx][7:0]  <= w_mdr[7:0];
        if (!rst && w_we_hi) r_mem[w_idx][15:8] <= w_mdr[15:8];
    end

    assign MEM_OUT = r_mem_out;
    assign R       = r_r;
    assign ERR     = r_err;

endmodule

// File: tb/tb_lc3b_memory.sv
module tb_lc3b_memory;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        MIO_EN;
    logic        R_W;
    logic        DATA_SIZE;
    logic [15:0] MAR;
    logic [15:0] MDR_IN;
    logic [15:0] MEM_OUT;
    logic        R;
    logic        ERR;

    int checks = 0;
    int errors = 0;

    // Reference: word store keyed by word index, plus the last completed read.
    logic [15:0] mdl [int];
    logic [15:0] exp_out;

    lc3b_memory #(.WORDS(32768), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .MIO_EN(MIO_EN), .R_W(R_W), .DATA_SIZE(DATA_SIZE),
        .MAR(MAR), .MDR_IN(MDR_IN), .MEM_OUT(MEM_OUT), .R(R), .ERR(ERR)
    );

    always #5 clk = ~clk;

    // One complete request; cycle 0 starts just after the posedge below.
    task automatic req(input logic rw, input logic size, input logic [15:0] mar,
                       input logic [15:0] mdr, input string nm);
        int          wi;
        int          lat;
        bit          seen;
        logic        exp_err;
        logic [15:0] w;
        wi      = int'(mar[15:1]);
        exp_err = size & mar[0];
        if (!exp_err) begin
            if (rw) begin
                w = mdl.exists(wi) ? mdl[wi] : 16'h0000;
                if (size)        w = mdr;
                else if (mar[0]) w[15:8] = mdr[15:8];
                else             w[7:0]  = mdr[7:0];
                mdl[wi] = w;
            end else begin
                exp_out = mdl[wi];
            end
        end
        @(posedge clk); #1;
        MIO_EN = 1'b1; R_W = rw; DATA_SIZE = size; MAR = mar; MDR_IN = mdr;
        seen = 0; lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (R) begin seen = 1; lat = c; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no R within 20 cycles", nm);
        end else begin
            if (lat !== LAT - 1) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", nm, lat, LAT - 1);
            end
            checks++;
            if (ERR !== exp_err) begin
                errors++;
                $display("FAIL %s err: got %b want %b", nm, ERR, exp_err);
            end
            checks++;
            if (MEM_OUT !== exp_out) begin
                errors++;
                $display("FAIL %s mem_out: got %h want %h", nm, MEM_OUT, exp_out);
            end
        end
        @(posedge clk); #1;
        MIO_EN = 1'b0;
        @(negedge clk);
        checks++;
        if (R !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse: R=%b ERR=%b after R cycle, want 0 0", nm, R, ERR);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; MIO_EN = 1'b0; R_W = 1'b0; DATA_SIZE = 1'b0; MAR = '0; MDR_IN = '0;
        exp_out = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (R !== 1'b0)   begin errors++; $display("FAIL reset_r: got %b want 0", R); end
        checks++;
        if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ERR); end
        checks++;
        if (MEM_OUT !== 16'h0000) begin
            errors++; $display("FAIL reset_mem_out: got %h want 0000", MEM_OUT);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_word_rw();
        req(1'b1, 1'b1, 16'h3000, 16'hBEEF, "word_wr");
        req(1'b0, 1'b1, 16'h3000, 16'h0000, "word_rd");
    endtask

    task automatic test_byte_write();
        req(1'b1, 1'b1, 16'h3000, 16'h1234, "byte_pre");
        req(1'b1, 1'b0, 16'h3001, 16'h5A5A, "byte_wr_hi");
        req(1'b0, 1'b1, 16'h3000, 16'h0000, "byte_rd_hi");
        req(1'b1, 1'b0, 16'h3000, 16'h5A5A, "byte_wr_lo");
        req(1'b0, 1'b1, 16'h3000, 16'h0000, "byte_rd_lo");
        req(1'b0, 1'b0, 16'h3001, 16'h0000, "byte_rd_odd");
    endtask

    task automatic test_unaligned();
        req(1'b1, 1'b1, 16'h4000, 16'h1111, "ua_pre");
        req(1'b0, 1'b1, 16'h3000, 16'h0000, "ua_rd_other");
        req(1'b1, 1'b1, 16'h4001, 16'h2222, "ua_wr");
        req(1'b0, 1'b1, 16'h4001, 16'h0000, "ua_rd");
        req(1'b0, 1'b1, 16'h4000, 16'h0000, "ua_rd_after");
    endtask

    task automatic test_abort();
        req(1'b1, 1'b1, 16'h5000, 16'h7777, "abort_pre");
        @(posedge clk); #1;
        MIO_EN = 1'b1; R_W = 1'b1; DATA_SIZE = 1'b1; MAR = 16'h5000; MDR_IN = 16'h0F0F;
        @(posedge clk); #1;
        @(posedge clk); #1 MIO_EN = 1'b0;
        // Next request starts in the following cycle; a stray R would break its latency.
        req(1'b0, 1'b1, 16'h5000, 16'h0000, "abort_rd");
    endtask

    task automatic test_reset_midway();
        @(posedge clk); #1;
        MIO_EN = 1'b1; R_W = 1'b1; DATA_SIZE = 1'b1; MAR = 16'h5000; MDR_IN = 16'hDEAD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; MIO_EN = 1'b0;
        exp_out = 16'h0000;
        @(negedge clk);
        checks++;
        if (R !== 1'b0 || ERR !== 1'b0) begin
            errors++; $display("FAIL rst_mid_r: R=%b ERR=%b want 0 0", R, ERR);
        end
        checks++;
        if (MEM_OUT !== 16'h0000) begin
            errors++; $display("FAIL rst_mid_mem_out: got %h want 0000", MEM_OUT);
        end
        req(1'b0, 1'b1, 16'h5000, 16'h0000, "rst_mid_rd");
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b, d1, d2;
        int r1, r2;
        bit prev;
        a = 16'($urandom); b = 16'($urandom);
        req(1'b1, 1'b1, 16'h0000, a, "b2b_pre0");
        req(1'b1, 1'b1, 16'h0002, b, "b2b_pre1");
        r1 = -1; r2 = -1; prev = 0; d1 = '0; d2 = '0;
        @(posedge clk); #1;
        MIO_EN = 1'b1; R_W = 1'b0; DATA_SIZE = 1'b1; MAR = 16'h0000;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (R && prev) begin
                checks++; errors++;
                $display("FAIL b2b_double_r: R high two cycles at cycle %0d", c);
            end
            prev = R;
            if (R) begin
                if (r1 < 0) begin
                    r1 = c; d1 = MEM_OUT;
                    @(posedge clk); #1 MAR = 16'h0002;
                    prev = 0;
                    // the posedge above ended the R cycle; the next negedge is c+1
                end else begin
                    r2 = c; d2 = MEM_OUT;
                    break;
                end
            end
        end
        @(posedge clk); #1 MIO_EN = 1'b0;
        exp_out = b;
        checks++;
        if (r1 !== LAT - 1) begin errors++; $display("FAIL b2b_first: R at %0d want %0d", r1, LAT - 1); end
        checks++;
        if (r2 < 0 || r2 - r1 !== LAT) begin
            errors++; $display("FAIL b2b_spacing: got %0d want %0d", r2 - r1, LAT);
        end
        checks++;
        if (d1 !== a) begin errors++; $display("FAIL b2b_data0: got %h want %h", d1, a); end
        checks++;
        if (d2 !== b) begin errors++; $display("FAIL b2b_data1: got %h want %h", d2, b); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] mar, mdr;
        logic rw, size;
        logic [7:0] by;
        for (int i = 0; i < 16; i++)
            req(1'b1, 1'b1, 16'h6000 + 16'(2 * i), 16'($urandom), "rnd_fill");
        for (int i = 0; i < 40; i++) begin
            mar  = 16'h6000 + 16'($urandom_range(0, 31));
            rw   = 1'($urandom);
            size = 1'($urandom);
            by   = 8'($urandom);
            mdr  = size ? 16'($urandom) : {by, by};
            req(rw, size, mar, mdr, "rnd");
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_write();
        test_unaligned();
        test_abort();
        test_reset_midway();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3b_memory.md
# lc3b_memory

Word-organized main memory for the LC-3b datapath. It responds to the datapath's MAR/MDR memory interface (MIO_EN, R_W, DATA_SIZE) and asserts the ready signal R after a fixed access latency, so the microsequencer can spin in a memory state until R. It supports byte and word accesses with LC-3b byte-lane rules. It is the responder end of the interface driven by the control store and datapath.

## Interface

Parameters:
- WORDS, 32768: number of 16-bit words; power of two; index = MAR[15:1] mod WORDS.
- LATENCY, 5: cycles from first MIO_EN-high cycle to the R cycle, inclusive; must be ≥ 2.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- MIO_EN  input  1  memory request; held high by the datapath until R.
- R_W  input  1  0 = read, 1 = write; stable while MIO_EN high.
- DATA_SIZE  input  1  0 = byte, 1 = word; stable while MIO_EN high.
- MAR  input  16  byte address; stable while MIO_EN high.
- MDR_IN  input  16  write data; for byte writes the datapath replicates the byte in both halves.
- MEM_OUT  output  16  read data; registered.
- R  output  1  ready; one-cycle pulse marking access completion.
- ERR  output  1  one-cycle pulse coincident with R on an unaligned word access.

## Operation

- FSM states: IDLE, BUSY, DONE.
- IDLE: if MIO_EN=1, latch MAR, R_W, DATA_SIZE, MDR_IN; load latency counter; go to BUSY. Otherwise stay in IDLE.
- BUSY: decrement the counter each cycle.
  - If MIO_EN drops, abort: go to IDLE, no array write, no R.
  - When the counter expires, perform the access and go to DONE.
- DONE: R=1 for this cycle only, then go to IDLE. MIO_EN in this cycle belongs to the finishing request and is ignored. A new request is accepted in the following IDLE cycle.
- Read, any size: MEM_OUT ← word[MAR[15:1]]; MAR[0] is ignored (byte selection is done in the datapath). MEM_OUT holds until the next completed read.
- Byte write: MAR[0]=0 writes MDR_IN[7:0] to the low byte; MAR[0]=1 writes MDR_IN[15:8] to the high byte. The other byte is untouched.
- Word write, MAR[0]=0: whole word ← MDR_IN.
- Word access with MAR[0]=1 (read or write): no array write, MEM_OUT unchanged, ERR=1 with R.
- Address wrap: the index uses only the low log2(WORDS) bits of MAR[15:1]; higher bits alias.
- Array contents are not cleared by rst. Unwritten locations are undefined.

## Timing

- Reset values: R=0, ERR=0, MEM_OUT=16'h0000, state=IDLE, counter=0.
- If MIO_EN first samples high in cycle 0, R and ERR are high in cycle LATENCY-1. For the default LATENCY=5, that is cycle 4.
- MEM_OUT is valid in the R cycle (registered at the same edge that raises R).
- A write updates the array at the edge that raises R. A read issued in the next accepted request observes the new data.
- Back-to-back requests: if MIO_EN stays high through the DONE cycle and the next cycle, the second request starts in the cycle after R. Its R falls LATENCY cycles after the first R. Minimum spacing between R pulses = LATENCY cycles.
- rst during BUSY or DONE: the next state is IDLE, the pending write is dropped, and R, ERR and MEM_OUT are cleared at that edge.
- R is never high for two consecutive cycles.

## Test plan

- Word write 16'hBEEF at MAR=16'h3000, then word read at 16'h3000 → R in cycle 4 of each request; read MEM_OUT=16'hBEEF; ERR=0.
- Byte write MDR_IN=16'h5A5A at MAR=16'h3001 over word 16'h1234 → word read at 16'h3000 returns 16'h5A34. Repeat at MAR=16'h3000 → returns 16'h5A5A.
- Word write at MAR=16'h4001 → ERR=1 with R; a read at 16'h4000 returns the prior contents. MEM_OUT is unchanged in the ERR cycle.
- MIO_EN dropped in cycle 2 of a write to 16'h5000 → no R, no ERR; a later read shows old data. A new request started right after is accepted normally.
- rst asserted in cycle 3 of a pending write → R=0, MEM_OUT=0 next cycle; the write is dropped; FSM is IDLE. A fresh read completes in LATENCY cycles.
- MIO_EN held high across two consecutive reads of 16'h0000 and 16'h0002 → R pulses exactly 5 cycles apart, each returning the correct word.
